// File: rtl/shift_exec_stage.sv
// Two-stage pipelined execute shifter (SLL / SRA / optional SRL) with valid/ready
// handshake, full backpressure and synchronous flush. Optional SRL path: SHIFT_SRL_EN.
module shift_exec_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [31:0]      in_data,
  input  logic [4:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_SRL = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  logic             r_s1_valid;
  op_e              r_s1_opcode;
  logic [31:0]      r_s1_data;
  logic [4:0]       r_s1_shamt;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [31:0]      r_s2_result;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_illegal;

  logic             w_s2_free;
  logic             w_s1_free;
  logic             w_in_xfer;

  logic             w_legal;
  logic             w_right;
  logic             w_fill;
  logic [31:0]      w_lvl0;
  logic [31:0]      w_lvl1;
  logic [31:0]      w_lvl2;
  logic [31:0]      w_lvl3;
  logic [31:0]      w_lvl4;
  logic [31:0]      w_lvl5;
  logic [31:0]      w_result;

  // Readiness ripples backwards from the output so a full pipe restarts the
  // same cycle out_ready rises.
  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s1_free = !r_s1_valid || w_s2_free;
  assign in_ready  = w_s1_free && !flush && !reset;
  assign w_in_xfer = in_valid && in_ready;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_legal = 1'b0;
    w_right = 1'b0;
    w_fill  = 1'b0;
    case (r_s1_opcode)
      OP_SLL: w_legal = 1'b1;
      OP_SRA: begin
        w_legal = 1'b1;
        w_right = 1'b1;
        w_fill  = r_s1_data[31];
      end
`ifdef SHIFT_SRL_EN
      OP_SRL: begin
        w_legal = 1'b1;
        w_right = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Log shifter: level k shifts by 2**k when shamt[k] is set.
  assign w_lvl0 = r_s1_data;
  assign w_lvl1 = !r_s1_shamt[0] ? w_lvl0 :
                  w_right ? {{1{w_fill}}, w_lvl0[31:1]} : {w_lvl0[30:0], 1'b0};
  assign w_lvl2 = !r_s1_shamt[1] ? w_lvl1 :
                  w_right ? {{2{w_fill}}, w_lvl1[31:2]} : {w_lvl1[29:0], 2'b0};
  assign w_lvl3 = !r_s1_shamt[2] ? w_lvl2 :
                  w_right ? {{4{w_fill}}, w_lvl2[31:4]} : {w_lvl2[27:0], 4'b0};
  assign w_lvl4 = !r_s1_shamt[3] ? w_lvl3 :
                  w_right ? {{8{w_fill}}, w_lvl3[31:8]} : {w_lvl3[23:0], 8'b0};
  assign w_lvl5 = !r_s1_shamt[4] ? w_lvl4 :
                  w_right ? {{16{w_fill}}, w_lvl4[31:16]} : {w_lvl4[15:0], 16'b0};

  assign w_result = w_legal ? w_lvl5 : r_s1_data;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_opcode <= OP_SLL;
      r_s1_data   <= '0;
      r_s1_shamt  <= '0;
      r_s1_tag    <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_free) begin
      r_s1_valid  <= w_in_xfer;
      r_s1_opcode <= op_e'(in_opcode);
      r_s1_data   <= in_data;
      r_s1_shamt  <= in_shamt;
      r_s1_tag    <= in_tag;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_valid   <= 1'b0;
      r_s2_result  <= '0;
      r_s2_tag     <= '0;
      r_s2_illegal <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid   <= r_s1_valid;
      r_s2_result  <= w_result;
      r_s2_tag     <= r_s1_tag;
      r_s2_illegal <= !w_legal;
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_tag     = r_s2_tag;
  assign out_illegal = r_s2_illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: queue-based reference model plus
// directed vectors with hand-computed results (build with or without SHIFT_SRL_EN).
module tb_shift_exec_stage;
  localparam int TAG_W = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_opcode = 2'b00;
  logic [31:0]      in_data = '0;
  logic [4:0]       in_shamt = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  shift_exec_stage #(.TAG_W(TAG_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_data     (in_data),
    .in_shamt    (in_shamt),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %0s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Reference: {illegal, result} straight from the shift semantics.
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [4:0] sh);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b00:   return {1'b0, d << sh};
      2'b01:   return {1'b0, sd >>> sh};
`ifdef SHIFT_SRL_EN
      2'b10:   return {1'b0, d >> sh};
`endif
      default: return {1'b1, d};
    endcase
  endfunction

  // Compare process: outputs checked mid-cycle; handshakes seen here take effect
  // at the following rising edge.
  always @(negedge clock) begin
    logic [32:0] m;
    exp_t        e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        check("out_valid_with_pending_op", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("model_result",  out_result,       exp_q[0].result);
          check("model_tag",     32'(out_tag),     32'(exp_q[0].tag));
          check("model_illegal", 32'(out_illegal), 32'(exp_q[0].illegal));
        end
      end
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      if (in_valid && in_ready) begin
        m = model(in_opcode, in_data, in_shamt);
        e.result  = m[31:0];
        e.tag     = in_tag;
        e.illegal = m[32];
        exp_q.push_back(e);
      end
    end
  end

  // Issues one op into an idle pipe and pins the two-cycle latency and result.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] sh, input logic [TAG_W-1:0] tag,
                        input logic [31:0] er, input logic ei);
    in_valid  = 1'b1;
    in_opcode = op;
    in_data   = d;
    in_shamt  = sh;
    in_tag    = tag;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check({name, "_not_yet_valid"}, 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    check({name, "_valid"},   32'(out_valid),   32'd1);
    check({name, "_result"},  out_result,       er);
    check({name, "_tag"},     32'(out_tag),     32'(tag));
    check({name, "_illegal"}, 32'(out_illegal), 32'(ei));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    int          budget;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_out_result",  out_result,       32'd0);
    check("rst_out_tag",     32'(out_tag),     32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_in_ready",    32'(in_ready),    32'd0);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed single ops
    run_op("sra_min_31", 2'b01, 32'h8000_0000, 5'd31, 5'd3, 32'hFFFF_FFFF, 1'b0);
    run_op("sll_one_31", 2'b00, 32'h0000_0001, 5'd31, 5'd4, 32'h8000_0000, 1'b0);
    run_op("sll_zero",   2'b00, 32'h1234_5678, 5'd0,  5'd5, 32'h1234_5678, 1'b0);
    run_op("sra_neg_16", 2'b01, 32'h8765_4321, 5'd16, 5'd6, 32'hFFFF_8765, 1'b0);
    run_op("sll_8",      2'b00, 32'hDEAD_BEEF, 5'd8,  5'd7, 32'hADBE_EF00, 1'b0);
    run_op("sra_pos_4",  2'b01, 32'h7000_0000, 5'd4,  5'd8, 32'h0700_0000, 1'b0);
`ifdef SHIFT_SRL_EN
    run_op("op10_srl",   2'b10, 32'hF000_0000, 5'd4,  5'd9, 32'h0F00_0000, 1'b0);
`else
    run_op("op10_ill",   2'b10, 32'hF000_0000, 5'd4,  5'd9, 32'hF000_0000, 1'b1);
`endif
    run_op("op11_ill",   2'b11, 32'hF000_0000, 5'd4,  5'd10, 32'hF000_0000, 1'b1);

    // Streaming: 8 back-to-back ops, one result per cycle in tag order
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        in_valid  = 1'b1;
        in_opcode = i[0] ? 2'b01 : 2'b00;
        in_data   = 32'h8000_00F0 ^ (i * 32'h1111);
        in_shamt  = 5'(i * 3);
        in_tag    = TAG_W'(i);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clock); #1;
      if (i >= 1) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_tag",   32'(out_tag),   i - 1);
      end
    end
    @(posedge clock); #1;

    // Backpressure: two accepts, then in_ready falls and the output holds
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'b1;
      in_opcode = 2'b01;
      in_data   = 32'hC000_0000 + k;
      in_shamt  = 5'(k + 1);
      in_tag    = TAG_W'(8 + k);
      check("stall_in_ready", 32'(in_ready), (k < 2) ? 32'd1 : 32'd0);
      if (k == 2) begin
        check("stall_head_tag", 32'(out_tag), 32'd8);
        held = out_result;
      end
      @(posedge clock); #1;
    end
    check("stall_result_stable", out_result,     held);
    check("stall_tag_stable",    32'(out_tag),   32'd8);
    check("stall_in_ready_low",  32'(in_ready),  32'd0);
    out_ready = 1'b1;
    #1;
    check("release_in_ready_comb", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    budget = 0;
    while ((exp_q.size() != 0 || out_valid) && budget < 20) begin
      @(posedge clock); #1;
      budget++;
    end
    check("stall_drained_in_budget", 32'(budget < 20), 32'd1);

    // Flush with both stages full; the flush-cycle input must be refused
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid  = 1'b1;
      in_opcode = 2'b00;
      in_data   = 32'h0000_0101 << k;
      in_shamt  = 5'd2;
      in_tag    = TAG_W'(20 + k);
      @(posedge clock); #1;
    end
    check("preflush_valid", 32'(out_valid), 32'd1);
    check("preflush_tag",   32'(out_tag),   32'd20);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_tag    = TAG_W'(22);
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_kills_s2", 32'(out_valid), 32'd0);
    repeat (2) begin
      @(posedge clock); #1;
      check("flush_stays_empty", 32'(out_valid), 32'd0);
    end
    run_op("post_flush", 2'b00, 32'h0000_00FF, 5'd4, 5'd23, 32'h0000_0FF0, 1'b0);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'b1;
      in_opcode = 2'b00;
      in_data   = 32'hA5A5_0001;
      in_shamt  = 5'(k + 1);
      in_tag    = TAG_W'(k + 1);
      @(posedge clock); #1;
    end
    check("prereset_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid",    32'(out_valid), 32'd0);
    check("async_rst_result",   out_result,     32'd0);
    check("async_rst_tag",      32'(out_tag),   32'd0);
    check("async_rst_in_ready", 32'(in_ready),  32'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("in_ready_after_midreset", 32'(in_ready), 32'd1);
    run_op("post_reset", 2'b01, 32'h8000_0010, 5'd4, 5'd30, 32'hF800_0001, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    check("final_nothing_pending", 32'(exp_q.size()), 32'd0);
    check("final_out_idle",        32'(out_valid),    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
# shift_exec_stage

Two-stage pipelined execute-stage shift unit between the decode/operand-fetch stage and writeback arbitration. It registers an operand, shift amount, opcode and destination tag, computes a 32-bit logical-left or arithmetic-right shift with a 5-level log shifter, and registers the result. Both sides use a valid/ready handshake with full backpressure. A synchronous flush discards in-flight operations on a branch redirect.

## Interface
Parameters:
- TAG_W, default 5: destination-register tag width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; kills all in-flight operations.
- in_valid  input  1  upstream operation present.
- in_ready  output  1  stage accepts an operation this cycle.
- in_opcode  input  2  00 SLL, 01 SRA, 10 SRL (only with SHIFT_SRL_EN), 11 illegal.
- in_data  input  32  operand.
- in_shamt  input  5  shift amount, 0..31.
- in_tag  input  TAG_W  destination tag, passed through unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_result  output  32  shifted value.
- out_tag  output  TAG_W  tag of out_result.
- out_illegal  output  1  opcode was illegal; out_result equals operand.

## Operation
- S1 register holds {valid, opcode, data, shamt, tag}. The combinational shifter sits between S1 and S2. S2 register holds {valid, result, tag, illegal}. The out_* ports are driven directly from S2.
- Shifter: five cascaded 2:1 mux levels, selected by shamt bits 0..4, with shift distances 1, 2, 4, 8 and 16.
  - SLL fills vacated bits with 0.
  - SRA fills vacated bits with data[31] at every level.
  - SRL fills vacated bits with 0.
  - shamt = 0 passes the operand through.
- Illegal opcode: result = data, illegal = 1. The operation still flows and is counted like any other.
- Handshake:
  - s2_free = !s2_valid || out_ready.
  - s1_free = !s1_valid || s2_free.
  - in_ready = s1_free && !flush && !reset.
  - An input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- Advance rules:
  - S2 loads from S1 when s2_free. S2 valid takes s1_valid.
  - S1 loads from the input when s1_free. S1 valid takes (in_valid && in_ready).
- Holding rules:
  - While out_valid && !out_ready, S2 contents hold stable.
  - While S1 is stalled, S1 contents hold stable.
- flush takes priority over everything:
  - Next cycle, s1_valid = s2_valid = 0. Data registers may hold stale values.
  - in_ready is 0 during the flush cycle, so no input is accepted.
  - An output transfer that coincides with flush still completes, because downstream sampled it that cycle.
- Reset values:
  - s1_valid = s2_valid = 0.
  - out_valid = 0, out_result = 0, out_tag = 0, out_illegal = 0.
  - in_ready = 0 while reset is asserted and 1 in the first cycle after deassertion.
- Reset asserted mid-operation drops all in-flight operations immediately, asynchronously.

## Timing
- Latency: an operation accepted at edge N appears on out_valid after edge N+1, provided there is no stall. That is 2 cycles from the in_valid cycle to the out_valid cycle.
- Throughput: 1 operation per cycle when out_ready is held high.
- Full pipeline with out_ready = 0: both stages hold and in_ready = 0. When out_ready rises, in_ready rises in the same cycle, combinationally.
- in_ready depends combinationally on out_ready and flush. out_* never depend combinationally on in_*.
- Tag order is preserved. No operation is dropped or duplicated except by flush or reset.

## Configuration
- SHIFT_SRL_EN:
  - Defined: opcode 10 performs a logical right shift with zero fill, and illegal = 0.
  - Undefined: opcode 10 is treated as illegal (result = operand, illegal = 1). The SRL fill path is not synthesised.
- Opcode 11 is illegal in both builds.

## Test plan
- SRA: data 0x80000000, shamt 31, tag 3 → two cycles later out_result 0xFFFFFFFF, out_tag 3, out_illegal 0.
- SLL: data 0x0000_0001, shamt 31 → 0x80000000. SLL with shamt 0 on 0x12345678 → 0x12345678.
- Streaming: 8 back-to-back ops with out_ready = 1 → 8 results on 8 consecutive cycles, tags in order. Then out_ready = 0 for 3 cycles with in_valid held → in_ready falls after 2 accepts and out_result stays stable; releasing out_ready drains with no loss.
- Flush: flush while both stages are valid → next cycle out_valid = 0. An input presented in the flush cycle is not accepted (in_ready = 0).
- Opcode 10, data 0xF0000000, shamt 4:
  - With SHIFT_SRL_EN → 0x0F000000, illegal 0.
  - Without SHIFT_SRL_EN → 0xF0000000, illegal 1.
  - Opcode 11 → passthrough with illegal 1 in both builds.
- Reset asserted mid-stream → out_valid, out_result and out_tag go to 0 asynchronously. After deassertion in_ready = 1 and the first new op completes with 2-cycle latency.
